// File: rtl/imm_gen_pipe_if.sv
// Handshake/bundle interface for imm_gen_pipe: upstream instruction input and
// downstream decoded-immediate output, parameterised by datapath width XLEN.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_imm, out_fmt, out_target, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_imm, out_fmt, out_target, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator: input-side decode, registered output
// stage plus one-entry skid buffer. Optional macro IMM_GEN_CSR_ZIMM_EN enables CSR zimm.
module imm_gen_pipe #(
  parameter int unsigned XLEN = 32
) (
  input logic          clk,
  input logic          rst,
  imm_gen_pipe_if.slave bus
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic            illegal;
  } bundle_t;

  bundle_t    dec;
  bundle_t    out_q, out_d;
  bundle_t    skid_q, skid_d;
  logic       out_valid_q, out_valid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       in_ready_q;
  logic       in_xfer;
  logic [31:0] imm32;
  logic [6:0]  opcode;

  // Decode runs on the input side so the output bundle comes straight from flops.
  always_comb begin
    opcode      = bus.in_inst[6:0];
    imm32       = '0;
    dec         = '0;
    dec.inst    = bus.in_inst;
    dec.pc      = bus.in_pc;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    case (opcode)
      OP_REG: dec.fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        dec.fmt = FMT_I;
        imm32   = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        imm32   = {{20{bus.in_inst[31]}}, bus.in_inst[31:25], bus.in_inst[11:7]};
      end
      OP_BRANCH: begin
        dec.fmt = FMT_B;
        imm32   = {{19{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[7],
                   bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        imm32   = {{11{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[19:12],
                   bus.in_inst[20], bus.in_inst[30:21], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        imm32   = {bus.in_inst[31:12], 12'b0};
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
`ifdef IMM_GEN_CSR_ZIMM_EN
    if (opcode == OP_SYSTEM && bus.in_inst[14]) begin
      dec.imm = XLEN'(bus.in_inst[19:15]);
    end
`endif
    dec.target = bus.in_pc + dec.imm;
  end

  assign in_xfer = bus.in_valid && in_ready_q;

  // The skid only fills while the output is stalled, so it always drains first.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || bus.out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_xfer) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_inst    = out_q.inst;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_target  = out_q.target;
  assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: drives XLEN=32 and XLEN=64 instances in lockstep and
// compares both against a depth-2 FIFO reference with spec-level immediate decode.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        drv_valid;
  logic [31:0] drv_inst;
  logic [63:0] drv_pc;
  logic        drv_ready;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) if32 ();
  imm_gen_pipe_if #(.XLEN(64)) if64 ();

  assign if32.in_valid  = drv_valid;
  assign if32.in_inst   = drv_inst;
  assign if32.in_pc     = drv_pc[31:0];
  assign if32.out_ready = drv_ready;
  assign if64.in_valid  = drv_valid;
  assign if64.in_inst   = drv_inst;
  assign if64.in_pc     = drv_pc;
  assign if64.out_ready = drv_ready;

  imm_gen_pipe #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
  imm_gen_pipe #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(if64));

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } bundle_t;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] tgt;
  } vec_t;

  bundle_t q[$];
  vec_t    vecs[9];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Reference decode: value of each immediate built arithmetically from the ISA rules.
  function automatic bundle_t ref_decode(input logic [31:0] inst, input logic [63:0] pc);
    bundle_t b;
    longint  s, sgn;
    s   = longint'($signed(inst));
    sgn = s >>> 31;
    b.inst = inst;
    b.pc   = pc;
    b.ill  = 1'b0;
    b.imm  = '0;
    case (inst[6:0])
      7'h33: b.fmt = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73: begin
        b.fmt = 3'd1;
        b.imm = s >>> 20;
`ifdef IMM_GEN_CSR_ZIMM_EN
        if (inst[6:0] == 7'h73 && inst[14]) b.imm = longint'(inst[19:15]);
`endif
      end
      7'h23: begin
        b.fmt = 3'd2;
        b.imm = (s >>> 25) * 32 + longint'(inst[11:7]);
      end
      7'h63: begin
        b.fmt = 3'd3;
        b.imm = sgn * 4096 + longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32
              + longint'(inst[11:8]) * 2;
      end
      7'h6F: begin
        b.fmt = 3'd5;
        b.imm = sgn * 1048576 + longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048
              + longint'(inst[30:21]) * 2;
      end
      7'h37, 7'h17: begin
        b.fmt = 3'd4;
        b.imm = (s >>> 12) * 4096;
      end
      default: begin
        b.fmt = 3'd7;
        b.ill = 1'b1;
      end
    endcase
    return b;
  endfunction

  task automatic chk_bundle(input string tag, input bundle_t b);
    logic [63:0] tgt;
    tgt = b.pc + b.imm;
    chk({tag, "_valid32"},  64'(if32.out_valid), 64'd1);
    chk({tag, "_inst32"},   64'(if32.out_inst), 64'(b.inst));
    chk({tag, "_pc32"},     64'(if32.out_pc), b.pc & 64'hFFFF_FFFF);
    chk({tag, "_imm32"},    64'(if32.out_imm), b.imm & 64'hFFFF_FFFF);
    chk({tag, "_fmt32"},    64'(if32.out_fmt), 64'(b.fmt));
    chk({tag, "_tgt32"},    64'(if32.out_target), tgt & 64'hFFFF_FFFF);
    chk({tag, "_ill32"},    64'(if32.out_illegal), 64'(b.ill));
    chk({tag, "_valid64"},  64'(if64.out_valid), 64'd1);
    chk({tag, "_inst64"},   64'(if64.out_inst), 64'(b.inst));
    chk({tag, "_pc64"},     if64.out_pc, b.pc);
    chk({tag, "_imm64"},    if64.out_imm, b.imm);
    chk({tag, "_fmt64"},    64'(if64.out_fmt), 64'(b.fmt));
    chk({tag, "_tgt64"},    if64.out_target, tgt);
    chk({tag, "_ill64"},    64'(if64.out_illegal), 64'(b.ill));
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid32"}, 64'(if32.out_valid), 64'd0);
    chk({tag, "_ready32"}, 64'(if32.in_ready), 64'd1);
    chk({tag, "_fields32"}, 64'({if32.out_inst, if32.out_pc, if32.out_imm, if32.out_fmt,
                                 if32.out_target, if32.out_illegal} != '0), 64'd0);
    chk({tag, "_valid64"}, 64'(if64.out_valid), 64'd0);
    chk({tag, "_ready64"}, 64'(if64.in_ready), 64'd1);
    chk({tag, "_fields64"}, 64'({if64.out_inst, if64.out_pc, if64.out_imm, if64.out_fmt,
                                 if64.out_target, if64.out_illegal} != '0), 64'd0);
  endtask

  // The stage behaves as a two-deep FIFO: ready while fewer than two bundles are held.
  task automatic check_model();
    chk("model_in_ready32",  64'(if32.in_ready),  64'(q.size() < 2));
    chk("model_in_ready64",  64'(if64.in_ready),  64'(q.size() < 2));
    chk("model_out_valid32", 64'(if32.out_valid), 64'(q.size() > 0));
    chk("model_out_valid64", 64'(if64.out_valid), 64'(q.size() > 0));
    if (q.size() > 0) chk_bundle("model", q[0]);
  endtask

  task automatic cycle();
    bit accept;
    @(negedge clk);
    check_model();
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      accept = drv_valid && (q.size() < 2);
      if (q.size() > 0 && drv_ready) void'(q.pop_front());
      if (accept) q.push_back(ref_decode(drv_inst, drv_pc));
    end
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops[11];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h00};
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 10)];
    if (w[6:0] == 7'h00) w[6:0] = 7'($urandom);
    return w;
  endfunction

  initial begin
    vecs[0] = '{"addi_m1",  32'hFFF00093, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 64'hFF};
    vecs[1] = '{"jal_p8",   32'h0080006F, 64'h1000, 64'd8, 3'd5, 1'b0, 64'h1008};
    vecs[2] = '{"lui_neg",  32'h800000B7, 64'h10, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0,
                64'hFFFF_FFFF_8000_0010};
    vecs[3] = '{"illegal",  32'h0000007F, 64'h20, 64'd0, 3'd7, 1'b1, 64'h20};
    vecs[4] = '{"r_add",    32'h002081B3, 64'h30, 64'd0, 3'd0, 1'b0, 64'h30};
    vecs[5] = '{"sw_m4",    32'hFE112E23, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0, 64'h1FFC};
    vecs[6] = '{"beq_p16",  32'h00000863, 64'h40, 64'd16, 3'd3, 1'b0, 64'h50};
    vecs[7] = '{"auipc_wrap", 32'h00001017, 64'hFFFF_F800, 64'h1000, 3'd4, 1'b0, 64'h1_0000_0800};
`ifdef IMM_GEN_CSR_ZIMM_EN
    vecs[8] = '{"csrrwi",   32'h3400D073, 64'h0, 64'd1, 3'd1, 1'b0, 64'd1};
`else
    vecs[8] = '{"csrrwi",   32'h3400D073, 64'h0, 64'h340, 3'd1, 1'b0, 64'h340};
`endif

    drv_valid = 1'b1;
    drv_inst  = 32'hFFF00093;
    drv_pc    = 64'h100;
    drv_ready = 1'b1;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drv_valid = 1'b0;
    chk_cleared("reset");

    // Table vectors: one bundle per cycle with downstream always ready.
    for (int i = 0; i < 9; i++) begin
      bundle_t b;
      drv_valid = 1'b1;
      drv_inst  = vecs[i].inst;
      drv_pc    = vecs[i].pc;
      cycle();
      b = '{vecs[i].inst, vecs[i].pc, vecs[i].imm, vecs[i].fmt, vecs[i].ill};
      chk_bundle(vecs[i].name, b);
      chk({vecs[i].name, "_tgt_tab"}, if64.out_target, vecs[i].tgt);
    end
    drv_valid = 1'b0;
    cycle();

    // Backpressure: A then B while stalled, then release.
    drv_ready = 1'b0;
    drv_valid = 1'b1; drv_inst = 32'h00A00093; drv_pc = 64'h200; cycle();
    drv_inst = 32'h00B00113; drv_pc = 64'h204; cycle();
    drv_valid = 1'b0;
    chk("bp_in_ready_full", 64'(if32.in_ready), 64'd0);
    chk("bp_hold_a", 64'(if32.out_inst), 64'h00A00093);
    cycle();
    chk("bp_still_a", 64'(if64.out_inst), 64'h00A00093);
    drv_ready = 1'b1;
    cycle();
    chk("bp_then_b", 64'(if32.out_inst), 64'h00B00113);
    chk("bp_ready_back", 64'(if32.in_ready), 64'd1);
    cycle();
    chk("bp_drained", 64'(if32.out_valid), 64'd0);

    // Mid-stream reset with skid full; offered input during reset is dropped.
    drv_ready = 1'b0;
    drv_valid = 1'b1; drv_inst = 32'h00100093; drv_pc = 64'h300; cycle();
    drv_inst = 32'h00200093; cycle();
    drv_inst = 32'h00300093; rst = 1'b1; cycle();
    rst = 1'b0; drv_valid = 1'b0;
    chk_cleared("midrst");
    drv_valid = 1'b1; drv_inst = 32'h00400093; drv_pc = 64'h310; cycle();
    drv_valid = 1'b0;
    chk("midrst_next_inst", 64'(if32.out_inst), 64'h00400093);
    drv_ready = 1'b1;
    cycle();
    chk("midrst_alone", 64'(if64.out_valid), 64'd0);

    // Randomised traffic against the FIFO reference.
    for (int n = 0; n < 1500; n++) begin
      drv_valid = ($urandom_range(0, 3) != 0);
      drv_ready = ($urandom_range(0, 2) != 0);
      drv_inst  = rand_inst();
      drv_pc    = {$urandom, $urandom};
      cycle();
    end

    drv_valid = 1'b0;
    drv_ready = 1'b1;
    for (int n = 0; n < 4; n++) cycle();
    chk("final_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
